// File: rtl/writeback_buffer.sv
// In-order result queue between execute/load and the register file write port,
// with combinational forwarding of the youngest pending write per lookup port.
module writeback_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_rd,
    input  logic [31:0]                in_data,
    input  logic                       wb_stall,
    output logic                       write_enable,
    output logic [4:0]                 write_reg,
    output logic [31:0]                write_data,
    input  logic [4:0]                 lookup_reg1,
    input  logic [4:0]                 lookup_reg2,
    output logic                       fwd_hit1,
    output logic                       fwd_hit2,
    output logic [31:0]                fwd_data1,
    output logic [31:0]                fwd_data2,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    rd_q   [DEPTH];
    logic [4:0]    rd_d   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];

    logic full;
    logic push;
    logic pop;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign count        = count_q;
    assign in_ready     = !full;
    assign write_enable = !empty && !wb_stall;
    assign write_reg    = rd_q[head_q];
    assign write_data   = data_q[head_q];

    // x0 results complete the handshake but are never stored.
    assign push = in_valid && in_ready && (in_rd != 5'd0);
    assign pop  = write_enable;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            rd_d[i]   = rd_q[i];
            data_d[i] = data_q[i];
        end
        if (push) begin
            rd_d[tail_q]   = in_rd;
            data_d[tail_q] = in_data;
            tail_d         = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Scan oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if ((lookup_reg1 != 5'd0) && (rd_q[head_q + PW'(i)] == lookup_reg1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_q[head_q + PW'(i)];
                end
                if ((lookup_reg2 != 5'd0) && (rd_q[head_q + PW'(i)] == lookup_reg2)) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_q[head_q + PW'(i)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= rd_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule

// File: doc/writeback_buffer.md
# writeback_buffer

Small in-order result queue that sits between the execute/load stages and the register file write port. It accepts destination/data pairs from producers through a valid/ready handshake and drains them to the register file one write per cycle. It also exposes combinational forwarding so that reads of a register with a pending write return the youngest queued value instead of the stale register file contents.

## Interface
- DEPTH, 4, number of queue entries; power of two, ≥2
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous reset, active-low
- in_valid  input  1  producer offers a result this cycle
- in_ready  output  1  buffer can accept; equals !full
- in_rd  input  5  destination register of offered result
- in_data  input  32  result value
- wb_stall  input  1  inhibits draining this cycle
- write_enable  output  1  to register file write enable
- write_reg  output  5  to register file write address (head entry)
- write_data  output  32  to register file write data (head entry)
- lookup_reg1, lookup_reg2  input  5 each  register addresses being read this cycle
- fwd_hit1, fwd_hit2  output  1 each  a queued entry targets the lookup register
- fwd_data1, fwd_data2  output  32 each  youngest matching queued value
- count  output  clog2(DEPTH)+1  occupied entries
- empty  output  1  count == 0

## Operation
- Circular buffer: head and tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
- Push: in_valid && in_ready at a rising edge. If in_rd != 0, the entry (in_rd, in_data) is written at tail, tail advances, and count increments. If in_rd == 0, the handshake completes but nothing is stored (x0 writes are discarded).
- Drain: write_enable = !empty && !wb_stall, combinational. write_reg and write_data always show the head entry; they are don't-care when empty. On a rising edge with write_enable high, head advances and count decrements.
- Simultaneous push and pop when not full: both occur and count is unchanged.
- When full, in_ready = 0, even if a pop happens in the same cycle. There is no same-cycle refill.
- Forwarding (per port, combinational):
  - Scans valid entries for rd == lookup_reg.
  - The youngest match (closest to tail) wins.
  - The head entry being written this cycle is included.
  - The entry being pushed this cycle is not included.
  - lookup_reg == 0 gives hit = 0, data = 0.
  - No match gives hit = 0, data = 0.
- No data transformation; 32-bit values pass through unchanged.

## Timing
- Reset (reset_n low, takes effect immediately):
  - head = tail = count = 0; all entries invalid.
  - in_ready = 1, empty = 1, write_enable = 0, fwd_hit1/2 = 0.
  - Entries are dropped if reset is asserted mid-drain; no write is issued after reset.
- Latency: a result pushed at edge N is at head after that edge and can drive write_enable in cycle N+1. The register file takes it at edge N+1 if wb_stall is low.
- Throughput: one push and one write per cycle sustained.
- in_ready, empty and count are functions of registered state only. in_ready does not depend on in_valid or wb_stall.
- Forwarding outputs settle combinationally within the cycle from lookup_reg and registered state.

## Test plan
- Reset mid-operation:
  - Stimulus: fill 3 entries, assert reset_n = 0 asynchronously between edges.
  - Required: immediately count = 0, empty = 1, write_enable = 0, in_ready = 1.
  - After release: no writes appear.
- Single pass-through:
  - Stimulus: push (rd = 5, 0xDEADBEEF) at edge 0, wb_stall = 0.
  - Required in cycle 1: write_enable = 1, write_reg = 5, write_data = 0xDEADBEEF.
  - Required after edge 1: empty = 1.
- Full and wrap-around:
  - Stimulus: wb_stall = 1; push rd = 1..4 with data 0x11..0x44.
  - Required: count = 4, in_ready = 0; a 5th push with in_valid = 1 is not accepted.
  - Stimulus: release the stall, keep pushing rd = 6..9.
  - Required: writes appear in order 1, 2, 3, 4, 6, 7, 8, 9 with matching data; pointers wrap correctly.
- Forwarding priority:
  - Stimulus: wb_stall = 1; queue (rd = 7, 0xA), (rd = 3, 0xB), (rd = 7, 0xC); lookup_reg1 = 7, lookup_reg2 = 3.
  - Required: fwd_hit1 = 1, fwd_data1 = 0xC; fwd_hit2 = 1, fwd_data2 = 0xB.
  - Stimulus: lookup_reg1 = 0.
  - Required: fwd_hit1 = 0.
- x0 discard:
  - Stimulus: push (rd = 0, 0x1234).
  - Required: handshake completes, count unchanged, no write_enable, lookups of 0 miss.
- Simultaneous push and pop:
  - Stimulus: count = 2, push (rd = 9, 0x99) while write_enable = 1.
  - Required: count stays 2, head advances, rd = 9 lands at the tail.
